// File: rtl/efpga_mem_pkg.sv
// Shared defaults and FSM state type for the eFPGA memory tile initiator.
package efpga_mem_pkg;
    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/efpga_mem_rsp_fifo.sv
// Synchronous response FIFO; the head entry is presented combinationally and reads zero when empty.
module efpga_mem_rsp_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] store_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = empty_o ? '0 : store_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) store_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/efpga_mem_initiator.sv
// Fabric-side initiator for the eFPGA memory tile: request stream to tile strobes,
// in-order read responses with credit flow control, and an array clear sequence.
module efpga_mem_initiator
    import efpga_mem_pkg::*;
#(
    parameter int unsigned         ADDR_W         = MEM_ADDR_W,
    parameter int unsigned         DATA_W         = MEM_DATA_W,
    parameter int unsigned         DEPTH          = 1024,
    parameter int unsigned         RD_LAT         = 1,
    parameter int unsigned         RSP_DEPTH      = 4,
    parameter bit                  CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]   CLEAR_VAL      = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    input  logic              clear_req_i,
    output logic              clear_busy_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic [DATA_W-1:0] mem_data_in_o,
    output logic              mem_wen_o,
    output logic              mem_ren_o,
    input  logic [DATA_W-1:0] mem_data_out_i
);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     credits_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic              run_en_q, clear_pend_q;
    logic              req_acc, rd_acc, rsp_pop, clr_last;
    logic              fifo_push, fifo_full, fifo_empty;

    // run_en_q keeps ready low while reset is held when no clear runs on release
    assign req_ready_o  = run_en_q && (state_q == ST_RUN) && (credits_q < CW'(RSP_DEPTH));
    assign req_acc      = req_valid_i && req_ready_o;
    assign rd_acc       = req_acc && !req_we_i;
    assign rsp_valid_o  = !fifo_empty;
    assign rsp_pop      = rsp_valid_o && rsp_ready_i;
    assign clear_busy_o = (state_q == ST_CLEAR);
    assign clr_last     = (clr_cnt_q == ADDR_W'(DEPTH - 1));
    assign fifo_push    = rd_pipe_q[RD_LAT-1] && (!fifo_full || rsp_pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_last) state_d = ST_RUN;
            ST_RUN:   if ((clear_req_i || clear_pend_q) && !req_acc) state_d = ST_DRAIN;
            ST_DRAIN: if (credits_q == '0) state_d = ST_CLEAR;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            run_en_q     <= 1'b0;
            clear_pend_q <= 1'b0;
            clr_cnt_q    <= '0;
            credits_q    <= '0;
            rd_pipe_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_en_q <= 1'b1;
            // A clear pulse colliding with an accepted request is held until a free cycle
            clear_pend_q <= (state_q == ST_RUN) && (clear_req_i || clear_pend_q) && req_acc;
            if (state_q == ST_CLEAR) clr_cnt_q <= clr_last ? '0 : clr_cnt_q + ADDR_W'(1);
            case ({rd_acc, rsp_pop})
                2'b10:   credits_q <= credits_q + CW'(1);
                2'b01:   credits_q <= credits_q - CW'(1);
                default: credits_q <= credits_q;
            endcase
            rd_pipe_q[0] <= mem_ren_o;
            for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_wen_o     <= 1'b0;
            mem_ren_o     <= 1'b0;
            mem_waddr_o   <= '0;
            mem_raddr_o   <= '0;
            mem_data_in_o <= '0;
        end else begin
            mem_wen_o <= 1'b0;
            mem_ren_o <= 1'b0;
            if (state_q == ST_CLEAR) begin
                mem_wen_o     <= 1'b1;
                mem_waddr_o   <= clr_cnt_q;
                mem_data_in_o <= CLEAR_VAL;
            end else if (req_acc && req_we_i) begin
                mem_wen_o     <= 1'b1;
                mem_waddr_o   <= req_addr_i;
                mem_data_in_o <= req_wdata_i;
            end else if (rd_acc) begin
                mem_ren_o   <= 1'b1;
                mem_raddr_o <= req_addr_i;
            end
        end
    end

    efpga_mem_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (fifo_push),
        .push_data_i (mem_data_out_i),
        .pop_i       (rsp_pop),
        .pop_data_o  (rsp_rdata_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );
endmodule
